prog_loader: RTL and testbench

Boot-time instruction-memory loader. It accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words, and writes them through a write port into the writable instruction memory starting at address 0. It verifies a trailing checksum and holds the CPU in reset until a load completes successfully. It sits between the host link (UART receiver or test bench) and the instruction memory; the CPU fetch side stays read-only.

---
 rtl/prog_loader.sv | 153 +++++++++++++++
 tb/tb_prog_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot-time instruction-memory loader: takes a length-prefixed, checksummed byte
// stream and writes big-endian 16-bit words into instruction memory from address 0.
`timescale 1ns/1ps

module prog_loader #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

  state_t          state, state_nxt;
  logic            accept;
  logic [7:0]      len_hi;
  logic [ADDR_W:0] len;
  logic [ADDR_W:0] idx;
  logic [ADDR_W:0] idx_inc;
  logic [7:0]      hi_byte;
  logic [7:0]      sum;
  logic [15:0]     len_full;
  logic            len_ok;
  logic            last_word;
  logic            chk_ok;

  assign accept    = in_valid & in_ready;
  assign len_full  = {len_hi, in_data};
  // Index is one bit wider than the address so a full 2^ADDR_W program ends cleanly.
  assign len_ok    = (len_full != 16'd0) && ({16'd0, len_full} <= MAX_WORDS);
  assign idx_inc   = idx + 1'b1;
  assign last_word = (idx_inc == len);
  assign chk_ok    = (8'(sum + in_data) == 8'd0);
  assign busy      = in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        if (accept) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        if (accept) state_nxt = len_ok ? S_DAT_HI : S_ERR;
      end
      S_DAT_HI: begin
        in_ready = 1'b1;
        if (accept) state_nxt = S_DAT_LO;
      end
      S_DAT_LO: begin
        in_ready = 1'b1;
        if (accept) state_nxt = last_word ? S_CHK : S_DAT_HI;
      end
      S_CHK: begin
        in_ready = 1'b1;
        if (accept) state_nxt = chk_ok ? S_DONE : S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_hi    <= '0;
      len       <= '0;
      idx       <= '0;
      hi_byte   <= '0;
      sum       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            sum <= '0;
            idx <= '0;
          end
        end
        S_LEN_HI: if (accept) len_hi <= in_data;
        S_LEN_LO: if (accept) len <= (ADDR_W + 1)'(len_full);
        S_DAT_HI: begin
          if (accept) begin
            hi_byte <= in_data;
            sum     <= sum + in_data;
          end
        end
        S_DAT_LO: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= idx[ADDR_W-1:0];
            mem_wdata <= {hi_byte, in_data};
            sum       <= sum + in_data;
            idx       <= idx_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // Status flags are registered from the next state so they settle one cycle
  // after the deciding byte and never glitch toward the CPU reset input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      error    <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      done     <= (state_nxt == S_DONE);
      error    <= (state_nxt == S_ERR);
      cpu_hold <= (state_nxt != S_DONE);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: driver pushes expected writes and frame
// outcomes from a byte-level model; a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_prog_loader;

  localparam int AW   = 4;
  localparam int MAXN = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  typedef struct {
    bit done;
    bit error;
    bit hold;
    int cycles;
  } res_t;

  wr_t         exp_wr[$];
  res_t        exp_res[$];
  logic [7:0]  tx[$];
  logic [15:0] words[$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe and every end of a busy period is compared
  // against the oldest expectation pushed by the driver.
  bit prev_busy = 1'b0;
  int busy_cnt  = 0;
  always @(negedge clk) begin
    wr_t  w;
    res_t r;
    if (mem_we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write at %0t",
                 mem_addr, mem_wdata, $time);
      end else begin
        w = exp_wr.pop_front();
        check("write_addr", 32'(mem_addr), 32'(w.addr));
        check("write_data", 32'(mem_wdata), 32'(w.data));
      end
    end
    if (busy === 1'b1) busy_cnt++;
    if (prev_busy && busy !== 1'b1) begin
      if (exp_res.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_end: busy fell with no frame outstanding at %0t", $time);
      end else begin
        r = exp_res.pop_front();
        check("done", 32'(done), 32'(r.done));
        check("error", 32'(error), 32'(r.error));
        check("cpu_hold", 32'(cpu_hold), 32'(r.hold));
        if (r.cycles >= 0) check("busy_cycles", busy_cnt, r.cycles);
      end
      busy_cnt = 0;
    end
    prev_busy = (busy === 1'b1);
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Presents tx[] byte by byte; gap is the percent chance of an idle cycle
  // (with garbage on in_data); start_at pulses start alongside that byte.
  task automatic send(input int gap, input int start_at);
    int  waited;
    bit  fired;
    for (int i = 0; i < tx.size(); i++) begin
      waited = 0;
      fired  = 1'b0;
      while (!fired) begin
        @(negedge clk);
        if ($urandom_range(99) < gap) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
        end else begin
          in_valid = 1'b1;
          in_data  = tx[i];
        end
        if (i == start_at && waited == 0) start = 1'b1;
        fired = in_valid && (in_ready === 1'b1);
        @(posedge clk);
        #1 start = 1'b0;
        waited++;
        if (!fired && waited > 100) begin
          vectors++;
          miscompares++;
          $display("FAIL byte_timeout: byte %0d not accepted within 100 cycles, expected acceptance", i);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Reference model: frame bytes, expected writes and outcome follow directly
  // from the frame format and the mod-256 checksum rule.
  task automatic run_frame(input int n, input bit bad, input int gap, input int start_at);
    logic [7:0] s;
    logic [7:0] chk;
    res_t       r;
    tx.delete();
    tx.push_back(8'(n >> 8));
    tx.push_back(8'(n));
    if (n == 0 || n > MAXN) begin
      r.done = 1'b0; r.error = 1'b1; r.hold = 1'b1;
      r.cycles = (gap == 0) ? 2 : -1;
    end else begin
      s = 8'h00;
      for (int i = 0; i < n; i++) begin
        tx.push_back(words[i][15:8]);
        tx.push_back(words[i][7:0]);
        s = 8'(s + words[i][15:8] + words[i][7:0]);
        exp_wr.push_back('{addr: AW'(i), data: words[i]});
      end
      chk = 8'(8'h00 - s);
      if (bad) chk = 8'(chk + 8'h01);
      tx.push_back(chk);
      r.done = !bad; r.error = bad; r.hold = bad;
      r.cycles = (gap == 0) ? 2 * n + 3 : -1;
    end
    exp_res.push_back(r);
    do_start();
    send(gap, start_at);
    repeat (2) @(negedge clk);
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(16'($urandom));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res_t r;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal frame 00 02 01 F0 EC 10 13 at full rate.
    words = '{16'h01F0, 16'hEC10};
    run_frame(2, 1'b0, 0, -1);

    // Same frame with CHK = 0x14, then recovery.
    run_frame(2, 1'b1, 0, -1);
    check("err_sticky", 32'(error), 32'd1);
    check("err_in_ready", 32'(in_ready), 32'd0);
    run_frame(2, 1'b0, 0, -1);

    // Length limits.
    run_frame(0, 1'b0, 0, -1);
    run_frame(MAXN + 1, 1'b0, 0, -1);
    rand_words(MAXN);
    run_frame(MAXN, 1'b0, 0, -1);

    // Backpressure with garbage while invalid, and start while busy.
    words = '{16'h01F0, 16'hEC10};
    run_frame(2, 1'b0, 50, -1);
    run_frame(2, 1'b0, 0, 3);

    // Reset after the third byte aborts with no further writes.
    do_start();
    tx = '{8'h00, 8'h02, 8'h01};
    r.done = 1'b0; r.error = 1'b0; r.hold = 1'b1; r.cycles = -1;
    exp_res.push_back(r);
    send(0, -1);
    rst_n = 1'b0;
    @(negedge clk);
    #1 check_reset_values("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(2, 1'b0, 0, -1);

    // Randomized frames.
    for (int k = 0; k < 20; k++) begin
      int sel, n, gap, sa;
      bit bad;
      sel = $urandom_range(9);
      if (sel == 0)      n = 0;
      else if (sel == 1) n = MAXN + 1 + $urandom_range(100);
      else               n = $urandom_range(MAXN, 1);
      bad = ($urandom_range(3) == 0);
      gap = $urandom_range(60);
      sa  = ($urandom_range(1) == 1) ? $urandom_range(2 * MAXN + 2) : -1;
      rand_words((n >= 1 && n <= MAXN) ? n : 0);
      run_frame(n, bad, gap, sa);
    end

    repeat (5) @(negedge clk);
    check("pending_writes", exp_wr.size(), 32'd0);
    check("pending_results", exp_res.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
